// File: rtl/stdp_train_ctrl.sv
// Teacher-driven STDP training controller: a BTN rising edge with a one-hot
// Neuron target starts a run that drives the teacher pulse and enables STDP.
// The run ends when the target neuron fires SPIKE_LIMIT times or a timeout
// expires, then a quiet settle period passes before another run is accepted.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   BTN               training request level (rising edge starts a run)
//   Neuron            one-hot target class
//   Match             per-neuron "TX address is spike code" level
//   EN_STDP, EN_Pulse STDP / teacher injection enables
//   Pulse             teacher drive word
//   Busy              high outside IDLE
//   Class_done        sticky per-class completion bits
//   Timeout, Err      one-cycle event pulses
module stdp_train_ctrl #(
  parameter int                   TRAINING_NEURON_NUM = 10,
  parameter int                   PULSE_W             = 17,
  parameter logic [PULSE_W-1:0]   PULSE_AMP           = 17'h00400,
  parameter int                   SPIKE_LIMIT         = 6,
  parameter int                   TIMEOUT_CYC         = 60000,
  parameter int                   SETTLE_CYC          = 1000
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           BTN,
  input  logic [TRAINING_NEURON_NUM-1:0] Neuron,
  input  logic [TRAINING_NEURON_NUM-1:0] Match,
  output logic                           EN_STDP,
  output logic                           EN_Pulse,
  output logic [PULSE_W-1:0]             Pulse,
  output logic                           Busy,
  output logic [TRAINING_NEURON_NUM-1:0] Class_done,
  output logic                           Timeout,
  output logic                           Err
);

  localparam int N     = TRAINING_NEURON_NUM;
  localparam int CNT_W = $clog2(SPIKE_LIMIT + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {IDLE, TRAIN, SETTLE} state_t;

  state_t             state, state_nxt;
  logic               btn_q;
  logic [N-1:0]       match_q;
  logic [N-1:0]       target, target_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic [SET_W-1:0]   settle_cnt, settle_nxt;

  logic               done_set, tmo_evt, reject;
  logic               en_nxt, busy_nxt;
  logic [PULSE_W-1:0] pulse_nxt;
  logic [N-1:0]       done_nxt;

  logic btn_rise, neuron_onehot, spike, limit_hit, tmo_hit, settle_end;

  assign btn_rise      = BTN & ~btn_q;
  assign neuron_onehot = (Neuron != '0) && ((Neuron & (Neuron - 1'b1)) == '0);
  // Only a fresh rising edge on the latched target bit counts as a spike.
  assign spike         = |(Match & ~match_q & target);
  assign limit_hit     = spike && (cnt == CNT_W'(SPIKE_LIMIT - 1));
  assign tmo_hit       = (timer == TMR_W'(TIMEOUT_CYC - 1));
  assign settle_end    = (settle_cnt == SET_W'(SETTLE_CYC - 1));

  // State and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      // Loading BTN here keeps a button held through reset from starting a run.
      btn_q      <= BTN;
      match_q    <= '0;
      target     <= '0;
      cnt        <= '0;
      timer      <= '0;
      settle_cnt <= '0;
      EN_STDP    <= 1'b0;
      EN_Pulse   <= 1'b0;
      Pulse      <= '0;
      Busy       <= 1'b0;
      Class_done <= '0;
      Timeout    <= 1'b0;
      Err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      btn_q      <= BTN;
      match_q    <= Match;
      target     <= target_nxt;
      cnt        <= cnt_nxt;
      timer      <= timer_nxt;
      settle_cnt <= settle_nxt;
      EN_STDP    <= en_nxt;
      EN_Pulse   <= en_nxt;
      Pulse      <= pulse_nxt;
      Busy       <= busy_nxt;
      Class_done <= done_nxt;
      Timeout    <= tmo_evt;
      Err        <= reject;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    cnt_nxt    = cnt;
    timer_nxt  = timer;
    settle_nxt = settle_cnt;
    done_set   = 1'b0;
    tmo_evt    = 1'b0;
    reject     = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_rise) begin
          if (neuron_onehot) begin
            state_nxt  = TRAIN;
            target_nxt = Neuron;
            cnt_nxt    = '0;
            timer_nxt  = '0;
          end else begin
            reject = 1'b1;
          end
        end
      end
      TRAIN: begin
        if (spike && (cnt != CNT_W'(SPIKE_LIMIT)))
          cnt_nxt = cnt + CNT_W'(1);
        if (timer != TMR_W'(TIMEOUT_CYC))
          timer_nxt = timer + TMR_W'(1);
        // Limit is checked first so it wins a same-cycle tie with timeout.
        if (limit_hit) begin
          state_nxt  = SETTLE;
          done_set   = 1'b1;
          settle_nxt = '0;
        end else if (tmo_hit) begin
          state_nxt  = SETTLE;
          tmo_evt    = 1'b1;
          settle_nxt = '0;
        end
      end
      SETTLE: begin
        if (settle_end) state_nxt  = IDLE;
        else            settle_nxt = settle_cnt + SET_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output values derived from the upcoming state, registered above.
  always_comb begin
    en_nxt    = (state_nxt == TRAIN);
    pulse_nxt = en_nxt ? PULSE_AMP : '0;
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = Class_done | (done_set ? target : '0);
  end

endmodule

// File: tb/tb_stdp_train_ctrl.sv
module tb_stdp_train_ctrl;

  localparam int          N    = 10;
  localparam int          T    = 300;   // shortened timeout for simulation
  localparam int          S    = 40;    // shortened settle period
  localparam logic [16:0] AMP  = 17'h00400;

  logic         CLK = 1'b0;
  logic         RST, BTN;
  logic [N-1:0] Neuron, Match;
  logic         EN_STDP, EN_Pulse, Busy, Timeout, Err;
  logic [16:0]  Pulse;
  logic [N-1:0] Class_done;

  int checks = 0;
  int errors = 0;

  stdp_train_ctrl #(
    .TRAINING_NEURON_NUM(N), .PULSE_W(17), .PULSE_AMP(AMP),
    .SPIKE_LIMIT(6), .TIMEOUT_CYC(T), .SETTLE_CYC(S)
  ) dut (
    .CLK(CLK), .RST(RST), .BTN(BTN), .Neuron(Neuron), .Match(Match),
    .EN_STDP(EN_STDP), .EN_Pulse(EN_Pulse), .Pulse(Pulse), .Busy(Busy),
    .Class_done(Class_done), .Timeout(Timeout), .Err(Err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [N-1:0] n);
    Neuron = n;
    BTN    = 1'b1;
    tick();
    BTN    = 1'b0;
  endtask

  // One-cycle high on Match[i]; the edge is sampled at this tick.
  task automatic rise(input int i);
    Match[i] = 1'b1;
    tick();
    Match[i] = 1'b0;
  endtask

  task automatic chk_active(input string tag);
    chk({tag, "_stdp"},  32'(EN_STDP),  32'd1);
    chk({tag, "_pulse"}, 32'(Pulse),    32'(AMP));
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_stdp"},  32'(EN_STDP),  32'd0);
    chk({tag, "_enp"},   32'(EN_Pulse), 32'd0);
    chk({tag, "_pulse"}, 32'(Pulse),    32'd0);
  endtask

  // Called right after the run-ending tick.
  task automatic settle_wait(input string tag);
    repeat (S - 1) tick();
    chk({tag, "_busy_settle"}, 32'(Busy), 32'd1);
    tick();
    chk({tag, "_busy_idle"},   32'(Busy), 32'd0);
  endtask

  initial begin
    RST = 1'b1; BTN = 1'b0; Neuron = '0; Match = '0;
    tick(); tick();
    chk("rst_stdp", 32'(EN_STDP), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Class_done), 32'd0);
    chk("rst_pulse", 32'(Pulse), 32'd0);
    RST = 1'b0;
    tick();

    // Timeout run on class 0 with no Match activity.
    start(10'b0000000001);
    chk_active("tmo_start");
    chk("tmo_busy", 32'(Busy), 32'd1);
    repeat (T - 1) tick();
    chk("tmo_last_train", 32'(EN_STDP), 32'd1);
    chk("tmo_not_yet", 32'(Timeout), 32'd0);
    tick();
    chk("tmo_pulse", 32'(Timeout), 32'd1);
    chk_off("tmo_end");
    chk("tmo_done", 32'(Class_done), 32'd0);
    chk("tmo_busy_settle0", 32'(Busy), 32'd1);
    tick();
    chk("tmo_pulse_one", 32'(Timeout), 32'd0);
    repeat (S - 2) tick();
    chk("tmo_busy_settle", 32'(Busy), 32'd1);
    tick();
    chk("tmo_busy_idle", 32'(Busy), 32'd0);

    // Multi-hot start is rejected.
    start(10'b0000000011);
    chk("err_pulse", 32'(Err), 32'd1);
    chk("err_busy", 32'(Busy), 32'd0);
    tick();
    chk("err_one", 32'(Err), 32'd0);
    chk("err_idle", 32'(Busy), 32'd0);
    start(10'b0000000000);
    chk("err_zero", 32'(Err), 32'd1);
    tick();

    // Class 2: six edges 20 cycles apart, with a BTN press mid-run.
    start(10'b0000000100);
    chk_active("c2_start");
    for (int k = 0; k < 6; k++) begin
      rise(2);
      if (k < 5) begin
        chk_active("c2_mid");
        if (k == 2) begin
          Neuron = 10'b0010000000;
          BTN = 1'b1;
          tick();
          BTN = 1'b0;
          rise(7);
          chk_active("c2_btn_ignored");
          repeat (17) tick();
        end else begin
          repeat (19) tick();
        end
      end
    end
    chk_off("c2_end");
    chk("c2_done", 32'(Class_done), 32'h004);
    // BTN edge during SETTLE must be ignored.
    Neuron = 10'b0000100000;
    BTN = 1'b1;
    tick();
    BTN = 1'b0;
    repeat (S - 2) tick();
    chk("c2_busy_settle", 32'(Busy), 32'd1);
    tick();
    chk("c2_busy_idle", 32'(Busy), 32'd0);
    tick(); tick();
    chk("c2_no_restart", 32'(Busy), 32'd0);

    // Class 3: Match[3] held 50 cycles counts once; Match[5] toggling ignored.
    start(10'b0000001000);
    Match[3] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      Match[5] = ~Match[5];
      tick();
    end
    chk_active("c3_held");
    Match = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      Match[3] = 1'b1;
      Match[5] = 1'b1;
      tick();
      if (k == 4) begin
        chk_off("c3_end");
        chk("c3_done", 32'(Class_done), 32'h00C);
      end else begin
        chk_active("c3_mid");
      end
      Match = '0;
      if (k < 4) tick();
    end
    settle_wait("c3");

    // Reset mid-run after three edges, with BTN held through reset.
    start(10'b0000010000);
    for (int k = 0; k < 3; k++) begin rise(4); tick(); end
    chk_active("rst_mid_pre");
    RST = 1'b1;
    BTN = 1'b1;
    tick();
    chk_off("rst_mid");
    chk("rst_mid_busy", 32'(Busy), 32'd0);
    chk("rst_mid_done", 32'(Class_done), 32'd0);
    chk("rst_mid_tmo", 32'(Timeout), 32'd0);
    chk("rst_mid_err", 32'(Err), 32'd0);
    RST = 1'b0;
    tick();
    chk("rst_btn_held", 32'(Busy), 32'd0);
    BTN = 1'b0;
    tick();
    start(10'b0000010000);
    for (int k = 0; k < 5; k++) begin rise(4); tick(); end
    chk_active("rst_fresh5");
    rise(4);
    chk_off("rst_fresh6");
    chk("rst_fresh_done", 32'(Class_done), 32'h010);
    settle_wait("c4");

    // Limit and timeout on the same cycle: limit wins.
    start(10'b1000000000);
    for (int k = 0; k < 5; k++) begin rise(9); tick(); end
    repeat (T - 11) tick();
    chk_active("tie_pre");
    rise(9);
    chk("tie_tmo", 32'(Timeout), 32'd0);
    chk("tie_done", 32'(Class_done), 32'h210);
    chk_off("tie_end");
    settle_wait("tie");

    // Every class in turn; done bits accumulate, retraining permitted.
    for (int c = 0; c < N; c++) begin
      start(N'(1) << c);
      repeat (5) begin rise(c); tick(); end
      rise(c);
      chk("seq_end", 32'(EN_STDP), 32'd0);
      settle_wait("seq");
    end
    chk("seq_all_done", 32'(Class_done), 32'h3FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
